// File: rtl/apb_i2c_slave_pkg.sv
// Shared types and constants for the APB-programmable I2C target.
package apb_i2c_slave_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX_BYTE   = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX_BYTE   = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } i2c_slv_state_e;

    // Register select values (PADDR[5:2])
    localparam logic [3:0] REG_OWNADDR = 4'd0;
    localparam logic [3:0] REG_CTRL    = 4'd1;
    localparam logic [3:0] REG_RX      = 4'd2;
    localparam logic [3:0] REG_STATUS  = 4'd3;
    localparam logic [3:0] REG_TX      = 4'd4;
    localparam logic [3:0] REG_CMD     = 4'd5;

    // STATUS bit positions
    localparam int ST_RW   = 7;
    localparam int ST_BUSY = 6;
    localparam int ST_OVR  = 5;
    localparam int ST_UDR  = 4;
    localparam int ST_STOP = 3;
    localparam int ST_TXE  = 2;
    localparam int ST_RXF  = 1;
    localparam int ST_IRQ  = 0;

endpackage

// File: rtl/apb_i2c_slave_if.sv
// APB bus bundle between the host and the I2C target.
interface apb_i2c_slave_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_slave_bus_mon.sv
// SCL/SDA synchronisers and single-cycle bus event pulses.
module apb_i2c_slave_bus_mon #(
    parameter int SYNC_STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_q;
    logic                   sda_q;

    // Synchronise the pads (idle-high bus) and keep one cycle of history for edges
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/apb_i2c_slave.sv
// APB-programmable I2C target: register file plus bus-protocol FSM.
//
// state       | meaning
// S_IDLE      | bus free or block disabled, SDA released
// S_ADDR      | shifting in the address byte
// S_ADDR_ACK  | address matched, driving ACK for one SCL low-high-low
// S_RX_BYTE   | receiving a data byte from the master
// S_RX_ACK    | driving ACK (or leaving NACK) for the received byte
// S_TX_BYTE   | driving a data byte, MSB first, one bit per SCL fall
// S_TX_ACK    | SDA released, sampling the master's ACK/NACK
// S_WAIT_STOP | not addressed or master NACKed; ignore bus until START/STOP
module apb_i2c_slave
    import apb_i2c_slave_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SYNC_STAGES    = 2
) (
    input  logic           HCLK,
    input  logic           HRESET,
    apb_i2c_slave_if.slave apb,
    output logic           interrupt_o,
    input  logic           scl_pad_i,
    output logic           scl_pad_o,
    output logic           scl_padoen_o,
    input  logic           sda_pad_i,
    output logic           sda_pad_o,
    output logic           sda_padoen_o
);
    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    apb_i2c_slave_bus_mon #(.SYNC_STAGES(SYNC_STAGES)) u_bus_mon (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .scl_i     (scl_pad_i),
        .sda_i     (sda_pad_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Registers
    logic [6:0] own_addr;
    logic       ctrl_en, ctrl_ien;
    logic [7:0] rx_data, tx_data;
    logic       st_rw, st_busy, st_ovr, st_udr, st_stop, st_txe, st_rxf, irq_flag;
    logic       int_q;

    // FSM state and datapath
    i2c_slv_state_e state, state_nxt;
    logic [2:0] bit_cnt, cnt_nxt;
    logic [7:0] shifter, shift_nxt;
    logic       phase_q, phase_nxt;
    logic       ack_ok, ack_nxt;
    logic       sda_oe, oe_nxt;
    logic       ev_addr_hit, ev_rx_ok, ev_rx_ovr, ev_tx_load, ev_stop;

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [3:0] reg_sel;
    logic       apb_wr, apb_rd, en_clr;
    logic [7:0] rx_byte, tx_load_val, status;
    logic       unused_apb;

    assign paddr       = apb.PADDR;
    assign reg_sel     = paddr[5:2];
    assign apb_wr      = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign apb_rd      = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    // Disabling takes effect on the same edge that writes CTRL
    assign en_clr      = apb_wr && (reg_sel == REG_CTRL) && !apb.PWDATA[7];
    assign rx_byte     = {shifter[6:0], sda_s};
    assign tx_load_val = st_txe ? 8'hFF : tx_data;
    assign unused_apb  = ^{paddr[APB_ADDR_WIDTH-1:6], paddr[1:0], apb.PWDATA[31:8]};

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oe;
    assign interrupt_o  = int_q;
    assign apb.PREADY   = 1'b1;
    assign apb.PSLVERR  = 1'b0;

    // FSM state and bit-level datapath registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shifter <= '0;
            phase_q <= 1'b0;
            ack_ok  <= 1'b0;
            sda_oe  <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            shifter <= shift_nxt;
            phase_q <= phase_nxt;
            ack_ok  <= ack_nxt;
            sda_oe  <= oe_nxt;
        end
    end

    // Next-state, SDA drive and register-update events; STOP beats disable beats START
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt;
        shift_nxt   = shifter;
        phase_nxt   = phase_q;
        ack_nxt     = ack_ok;
        oe_nxt      = sda_oe;
        ev_addr_hit = 1'b0;
        ev_rx_ok    = 1'b0;
        ev_rx_ovr   = 1'b0;
        ev_tx_load  = 1'b0;
        ev_stop     = 1'b0;
        if (stop_det) begin
            state_nxt = S_IDLE;
            oe_nxt    = 1'b1;
            phase_nxt = 1'b0;
            ev_stop   = 1'b1;
        end else if (!ctrl_en || en_clr) begin
            state_nxt = S_IDLE;
            oe_nxt    = 1'b1;
            phase_nxt = 1'b0;
        end else if (start_det) begin
            state_nxt = S_ADDR;
            cnt_nxt   = '0;
            oe_nxt    = 1'b1;
            phase_nxt = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    shift_nxt = rx_byte;
                    cnt_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        phase_nxt = 1'b0;
                        if (rx_byte[7:1] == own_addr) begin
                            state_nxt   = S_ADDR_ACK;
                            ev_addr_hit = 1'b1;
                        end else begin
                            state_nxt = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oe_nxt    = 1'b0;
                        phase_nxt = 1'b1;
                    end else begin
                        phase_nxt = 1'b0;
                        cnt_nxt   = '0;
                        if (st_rw) begin
                            state_nxt  = S_TX_BYTE;
                            ev_tx_load = 1'b1;
                            shift_nxt  = tx_load_val;
                            oe_nxt     = tx_load_val[7];
                        end else begin
                            state_nxt = S_RX_BYTE;
                            oe_nxt    = 1'b1;
                        end
                    end
                end
                S_RX_BYTE: if (scl_rise) begin
                    shift_nxt = rx_byte;
                    cnt_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_RX_ACK;
                        phase_nxt = 1'b0;
                        ack_nxt   = ~st_rxf;
                        ev_rx_ok  = ~st_rxf;
                        ev_rx_ovr = st_rxf;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oe_nxt    = ~ack_ok;
                        phase_nxt = 1'b1;
                    end else begin
                        oe_nxt    = 1'b1;
                        phase_nxt = 1'b0;
                        state_nxt = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (scl_rise) begin
                        cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = S_TX_ACK;
                            phase_nxt = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_nxt = {shifter[6:0], 1'b1};
                        oe_nxt    = shifter[6];
                    end
                end
                S_TX_ACK: begin
                    if (scl_fall && !phase_q) begin
                        oe_nxt = 1'b1;
                    end else if (scl_rise) begin
                        if (sda_s) state_nxt = S_WAIT_STOP;
                        else       phase_nxt = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        state_nxt  = S_TX_BYTE;
                        phase_nxt  = 1'b0;
                        cnt_nxt    = '0;
                        ev_tx_load = 1'b1;
                        shift_nxt  = tx_load_val;
                        oe_nxt     = tx_load_val[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: APB writes and clears first, FSM events after so a set wins
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            own_addr <= '0;
            ctrl_en  <= 1'b0;
            ctrl_ien <= 1'b0;
            rx_data  <= '0;
            tx_data  <= '0;
            st_rw    <= 1'b0;
            st_busy  <= 1'b0;
            st_ovr   <= 1'b0;
            st_udr   <= 1'b0;
            st_stop  <= 1'b0;
            st_txe   <= 1'b1;
            st_rxf   <= 1'b0;
            irq_flag <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            if (apb_wr) begin
                case (reg_sel)
                    REG_OWNADDR: own_addr <= apb.PWDATA[6:0];
                    REG_CTRL: begin
                        ctrl_en  <= apb.PWDATA[7];
                        ctrl_ien <= apb.PWDATA[6];
                    end
                    REG_CMD: begin
                        if (apb.PWDATA[0]) irq_flag <= 1'b0;
                        if (apb.PWDATA[1]) begin
                            st_ovr  <= 1'b0;
                            st_udr  <= 1'b0;
                            st_stop <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (apb_rd && reg_sel == REG_RX) st_rxf <= 1'b0;
            if (ev_addr_hit) begin
                st_rw    <= rx_byte[0];
                st_busy  <= 1'b1;
                irq_flag <= 1'b1;
            end
            if (ev_rx_ok) begin
                rx_data  <= rx_byte;
                st_rxf   <= 1'b1;
                irq_flag <= 1'b1;
            end
            if (ev_rx_ovr) begin
                st_ovr   <= 1'b1;
                irq_flag <= 1'b1;
            end
            if (ev_tx_load) begin
                st_txe   <= 1'b1;
                irq_flag <= 1'b1;
                if (st_txe) st_udr <= 1'b1;
            end
            if (ev_stop) begin
                st_busy <= 1'b0;
                if (st_busy) begin
                    st_stop  <= 1'b1;
                    irq_flag <= 1'b1;
                end
            end
            // A fresh TX write must leave TXE clear even if a load happens on the same edge
            if (apb_wr && reg_sel == REG_TX) begin
                tx_data <= apb.PWDATA[7:0];
                st_txe  <= 1'b0;
            end
            int_q <= irq_flag & ctrl_ien;
        end
    end

    // STATUS image
    always_comb begin
        status          = '0;
        status[ST_RW]   = st_rw;
        status[ST_BUSY] = st_busy;
        status[ST_OVR]  = st_ovr;
        status[ST_UDR]  = st_udr;
        status[ST_STOP] = st_stop;
        status[ST_TXE]  = st_txe;
        status[ST_RXF]  = st_rxf;
        status[ST_IRQ]  = irq_flag;
    end

    // APB read mux, zero-extended
    always_comb begin
        apb.PRDATA = '0;
        case (reg_sel)
            REG_OWNADDR: apb.PRDATA[6:0] = own_addr;
            REG_CTRL:    apb.PRDATA[7:6] = {ctrl_en, ctrl_ien};
            REG_RX:      apb.PRDATA[7:0] = rx_data;
            REG_STATUS:  apb.PRDATA[7:0] = status;
            REG_TX:      apb.PRDATA[7:0] = tx_data;
            default: ;
        endcase
    end

endmodule
